uart_tx_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares the single UART transmitter among NUM_REQ byte-stream requesters. It sits between host-side producers (console, debug, status engines) and the transmitter's valid/ready byte interface. A grant is held for a whole packet, so bytes from different requesters never interleave. MAX_BURST and IDLE_TIMEOUT forcibly release a grant so one requester cannot starve the others.

---
 rtl/uart_tx_arbiter_if.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 64 ++++++
 tb/tb_uart_tx_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: byte-stream bus between the requesters, the arbiter and the UART transmitter
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 uart_tx_valid;
  logic [7:0]           uart_tx_data;
  logic                 uart_tx_ready;
  logic                 grant_valid;
  logic [ID_W-1:0]      grant_id;
  logic                 forced_release;
  modport master (
    input  req_valid, req_data, req_last, uart_tx_ready,
    output req_ready, uart_tx_valid, uart_tx_data, grant_valid, grant_id, forced_release
  );
  modport slave (
    output req_valid, req_data, req_last, uart_tx_ready,
    input  req_ready, uart_tx_valid, uart_tx_data, grant_valid, grant_id, forced_release
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin sharing of one UART transmitter with burst/idle forced release
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 64,
  parameter int IDLE_TIMEOUT = 1024
) (
  input logic clk,
  input logic rst_n,
  uart_tx_arbiter_if.master bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0]  BURST_M1 = 8'(MAX_BURST - 1);
  localparam logic [15:0] IDLE_M1  = 16'(IDLE_TIMEOUT - 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [ID_W-1:0] last_id, sel, idx;
  logic [7:0] byte_cnt;
  logic [15:0] idle_cnt;
  logic granted, xfer, rel_norm, rel_forced;
  assign granted = state == GRANT;
  assign bus.grant_valid = granted;
  assign bus.uart_tx_valid = granted & bus.req_valid[bus.grant_id];
  assign bus.uart_tx_data = bus.req_data[{bus.grant_id, 3'b000} +: 8];
  assign bus.req_ready = granted ? (NUM_REQ'(bus.uart_tx_ready) << bus.grant_id) : '0;
  assign xfer = bus.uart_tx_valid & bus.uart_tx_ready;
  // Scan downward so the closest requester after last_id overwrites the rest.
  always_comb begin
    sel = '0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(last_id) + k) % NUM_REQ);
      if (bus.req_valid[idx]) sel = idx;
    end
  end
  always_comb begin
    rel_norm = xfer & bus.req_last[bus.grant_id];
    rel_forced = (xfer & (byte_cnt == BURST_M1)) | (!xfer & (idle_cnt == IDLE_M1));
    state_n = (state == IDLE) ? ((|bus.req_valid) ? GRANT : IDLE) : ((rel_norm | rel_forced) ? IDLE : GRANT);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.grant_id <= '0;
      last_id <= ID_W'(NUM_REQ - 1);
      byte_cnt <= '0;
      idle_cnt <= '0;
      bus.forced_release <= 1'b0;
    end else begin
      bus.forced_release <= granted & !rel_norm & rel_forced;
      if (!granted) begin
        if (|bus.req_valid) begin
          bus.grant_id <= sel;
          byte_cnt <= '0;
          idle_cnt <= '0;
        end
      end else begin
        byte_cnt <= xfer ? byte_cnt + 8'd1 : byte_cnt;
        idle_cnt <= xfer ? '0 : ((idle_cnt == 16'hFFFF) ? idle_cnt : idle_cnt + 16'd1);
        if (state_n == IDLE) last_id <= bus.grant_id;
      end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios for the UART transmit arbiter (MAX_BURST=4, IDLE_TIMEOUT=8)
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  uart_tx_arbiter_if #(.NUM_REQ(4)) bus();
  uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(4), .IDLE_TIMEOUT(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs;
    bus.req_valid = '0;
    bus.req_last = '0;
    bus.req_data = '0;
    bus.uart_tx_ready = 1'b0;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    bus.req_valid = '1;
    bus.req_last = '1;
    bus.req_data = 32'h44332211;
    bus.uart_tx_ready = 1'b1;
    step();
    n_checks++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL rst_grant_valid: got %b expected 0", bus.grant_valid); end
    n_checks++; if (bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_grant_id: got %0d expected 0", bus.grant_id); end
    n_checks++; if (bus.forced_release !== 1'b0) begin n_fail++; $display("FAIL rst_forced: got %b expected 0", bus.forced_release); end
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_req_ready: got %b expected 0000", bus.req_ready); end
    n_checks++; if (bus.uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %b expected 0", bus.uart_tx_valid); end
    do_reset();
  endtask
  task automatic test_single_packet;
    do_reset();
    bus.req_valid = 4'b0100;
    bus.req_data[23:16] = 8'hA1;
    bus.uart_tx_ready = 1'b1;
    #1;
    n_checks++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL single_arb_gv: got %b expected 0", bus.grant_valid); end
    n_checks++; if (bus.uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle_txv: got %b expected 0", bus.uart_tx_valid); end
    step();
    n_checks++; if (bus.grant_valid !== 1'b1) begin n_fail++; $display("FAIL single_gv: got %b expected 1", bus.grant_valid); end
    n_checks++; if (bus.grant_id !== 2'd2) begin n_fail++; $display("FAIL single_gid: got %0d expected 2", bus.grant_id); end
    n_checks++; if (bus.uart_tx_valid !== 1'b1) begin n_fail++; $display("FAIL single_txv: got %b expected 1", bus.uart_tx_valid); end
    n_checks++; if (bus.uart_tx_data !== 8'hA1) begin n_fail++; $display("FAIL single_b1: got %h expected a1", bus.uart_tx_data); end
    n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b expected 0100", bus.req_ready); end
    step();
    bus.req_data[23:16] = 8'hA2;
    #1;
    n_checks++; if (bus.uart_tx_data !== 8'hA2 || bus.uart_tx_valid !== 1'b1) begin n_fail++; $display("FAIL single_b2: got %h/%b expected a2/1", bus.uart_tx_data, bus.uart_tx_valid); end
    step();
    bus.req_data[23:16] = 8'hA3;
    bus.req_last = 4'b0100;
    #1;
    n_checks++; if (bus.uart_tx_data !== 8'hA3 || bus.grant_valid !== 1'b1) begin n_fail++; $display("FAIL single_b3: got %h/%b expected a3/1", bus.uart_tx_data, bus.grant_valid); end
    step();
    idle_inputs();
    #1;
    n_checks++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL single_release: got %b expected 0", bus.grant_valid); end
    n_checks++; if (bus.forced_release !== 1'b0) begin n_fail++; $display("FAIL single_forced: got %b expected 0", bus.forced_release); end
  endtask
  task automatic test_round_robin;
    do_reset();
    bus.req_valid = 4'b1111;
    bus.req_last = 4'b1111;
    bus.req_data = 32'h13121110;
    bus.uart_tx_ready = 1'b1;
    #1;
    n_checks++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL rr_start_gv: got %b expected 0", bus.grant_valid); end
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'(k % 4)) begin n_fail++; $display("FAIL rr_grant%0d: got %b/%0d expected 1/%0d", k, bus.grant_valid, bus.grant_id, k % 4); end
      n_checks++; if (bus.uart_tx_data !== 8'(8'h10 + k % 4)) begin n_fail++; $display("FAIL rr_data%0d: got %h expected %h", k, bus.uart_tx_data, 8'(8'h10 + k % 4)); end
      step();
      n_checks++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL rr_bubble%0d: got %b expected 0", k, bus.grant_valid); end
    end
    idle_inputs();
  endtask
  task automatic test_back_to_back_backpressure;
    do_reset();
    bus.req_valid = 4'b0010;
    bus.req_data[15:8] = 8'hB0;
    bus.uart_tx_ready = 1'b1;
    step();
    bus.req_valid = 4'b0011;
    bus.req_data[7:0] = 8'hD0;
    bus.req_last = 4'b0001;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) step();
      bus.uart_tx_ready = (c % 2 == 0);
      bus.req_data[15:8] = 8'(8'hB0 + c / 2);
      bus.req_last[1] = (c == 6);
      #1;
      n_checks++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd1) begin n_fail++; $display("FAIL bp_hold%0d: got %b/%0d expected 1/1", c, bus.grant_valid, bus.grant_id); end
      n_checks++; if (bus.uart_tx_data !== 8'(8'hB0 + c / 2)) begin n_fail++; $display("FAIL bp_data%0d: got %h expected %h", c, bus.uart_tx_data, 8'(8'hB0 + c / 2)); end
      n_checks++; if (bus.req_ready !== ((c % 2 == 0) ? 4'b0010 : 4'b0000)) begin n_fail++; $display("FAIL bp_ready%0d: got %b expected %b", c, bus.req_ready, (c % 2 == 0) ? 4'b0010 : 4'b0000); end
    end
    step();
    bus.req_valid = 4'b0001;
    bus.req_last = 4'b0001;
    bus.uart_tx_ready = 1'b1;
    #1;
    n_checks++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b expected 0", bus.grant_valid); end
    n_checks++; if (bus.forced_release !== 1'b0) begin n_fail++; $display("FAIL bp_last_at_burst_forced: got %b expected 0", bus.forced_release); end
    step();
    n_checks++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL bp_next_grant: got %b/%0d expected 1/0", bus.grant_valid, bus.grant_id); end
    n_checks++; if (bus.uart_tx_data !== 8'hD0 || bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_next_data: got %h/%b expected d0/0001", bus.uart_tx_data, bus.req_ready); end
    idle_inputs();
  endtask
  task automatic test_max_burst;
    do_reset();
    bus.req_valid = 4'b1000;
    bus.req_data[31:24] = 8'hC1;
    bus.uart_tx_ready = 1'b1;
    step();
    bus.req_valid = 4'b1010;
    bus.req_data[15:8] = 8'hD1;
    bus.req_last = 4'b0010;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) step();
      bus.req_data[31:24] = 8'(8'hC1 + b);
      #1;
      n_checks++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd3) begin n_fail++; $display("FAIL burst_hold%0d: got %b/%0d expected 1/3", b, bus.grant_valid, bus.grant_id); end
      n_checks++; if (bus.uart_tx_data !== 8'(8'hC1 + b) || bus.forced_release !== 1'b0) begin n_fail++; $display("FAIL burst_byte%0d: got %h/%b expected %h/0", b, bus.uart_tx_data, bus.forced_release, 8'(8'hC1 + b)); end
    end
    step();
    n_checks++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL burst_release: got %b expected 0", bus.grant_valid); end
    n_checks++; if (bus.forced_release !== 1'b1) begin n_fail++; $display("FAIL burst_forced: got %b expected 1", bus.forced_release); end
    step();
    n_checks++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd1 || bus.uart_tx_data !== 8'hD1) begin n_fail++; $display("FAIL burst_other: got %b/%0d/%h expected 1/1/d1", bus.grant_valid, bus.grant_id, bus.uart_tx_data); end
    n_checks++; if (bus.forced_release !== 1'b0) begin n_fail++; $display("FAIL burst_pulse_width: got %b expected 0", bus.forced_release); end
    step();
    bus.req_valid = 4'b1000;
    bus.req_last = 4'b0000;
    bus.req_data[31:24] = 8'hC5;
    #1;
    n_checks++; if (bus.grant_valid !== 1'b0 || bus.forced_release !== 1'b0) begin n_fail++; $display("FAIL burst_bubble: got %b/%b expected 0/0", bus.grant_valid, bus.forced_release); end
    step();
    n_checks++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd3 || bus.uart_tx_data !== 8'hC5) begin n_fail++; $display("FAIL burst_resume: got %b/%0d/%h expected 1/3/c5", bus.grant_valid, bus.grant_id, bus.uart_tx_data); end
    idle_inputs();
  endtask
  task automatic test_idle_timeout;
    do_reset();
    bus.req_valid = 4'b0001;
    bus.req_data[7:0] = 8'hE1;
    bus.uart_tx_ready = 1'b1;
    step();
    n_checks++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd0 || bus.uart_tx_data !== 8'hE1) begin n_fail++; $display("FAIL idle_first: got %b/%0d/%h expected 1/0/e1", bus.grant_valid, bus.grant_id, bus.uart_tx_data); end
    step();
    bus.req_valid = 4'b0000;
    #1;
    for (int t = 0; t < 8; t++) begin
      if (t > 0) step();
      n_checks++; if (bus.grant_valid !== 1'b1 || bus.forced_release !== 1'b0 || bus.uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL idle_hold%0d: got %b/%b/%b expected 1/0/0", t, bus.grant_valid, bus.forced_release, bus.uart_tx_valid); end
    end
    step();
    n_checks++; if (bus.grant_valid !== 1'b0 || bus.forced_release !== 1'b1) begin n_fail++; $display("FAIL idle_release: got %b/%b expected 0/1", bus.grant_valid, bus.forced_release); end
    step();
    n_checks++; if (bus.forced_release !== 1'b0 || bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL idle_pulse_width: got %b/%b expected 0/0", bus.forced_release, bus.grant_valid); end
    idle_inputs();
  endtask
  task automatic test_reset_mid_grant;
    do_reset();
    bus.req_valid = 4'b0100;
    bus.req_data[23:16] = 8'hF1;
    bus.uart_tx_ready = 1'b1;
    step();
    n_checks++; if (bus.grant_id !== 2'd2 || bus.uart_tx_data !== 8'hF1) begin n_fail++; $display("FAIL mid_b1: got %0d/%h expected 2/f1", bus.grant_id, bus.uart_tx_data); end
    step();
    bus.req_data[23:16] = 8'hF2;
    #1;
    n_checks++; if (bus.uart_tx_data !== 8'hF2 || bus.uart_tx_valid !== 1'b1) begin n_fail++; $display("FAIL mid_b2: got %h/%b expected f2/1", bus.uart_tx_data, bus.uart_tx_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.grant_valid !== 1'b0 || bus.uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_gv_txv: got %b/%b expected 0/0", bus.grant_valid, bus.uart_tx_valid); end
    n_checks++; if (bus.req_ready !== 4'b0000 || bus.grant_id !== 2'd0 || bus.forced_release !== 1'b0) begin n_fail++; $display("FAIL mid_rst_regs: got %b/%0d/%b expected 0000/0/0", bus.req_ready, bus.grant_id, bus.forced_release); end
    step();
    rst_n = 1'b1;
    bus.req_valid = 4'b0101;
    bus.req_data[7:0] = 8'h11;
    #1;
    n_checks++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after_gv: got %b expected 0", bus.grant_valid); end
    step();
    n_checks++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd0 || bus.uart_tx_data !== 8'h11) begin n_fail++; $display("FAIL mid_first_winner: got %b/%0d/%h expected 1/0/11", bus.grant_valid, bus.grant_id, bus.uart_tx_data); end
    idle_inputs();
  endtask
  initial begin
    idle_inputs();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_back_to_back_backpressure();
    test_max_burst();
    test_idle_timeout();
    test_reset_mid_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
